vec_mem_sequencer: RTL and testbench
====================================

Name: vec_mem_sequencer

Overview:
- Sequences one vector or scalar load/store over a single element-wide data-memory port.
- Started by the decode-stage control signals `cl_mem_st` / `cl_mem_op`.
- Drives `mem_rdy` back to processor control, which stalls the pipeline (`pc_en`/`ex_en`) while a memory op in EX is incomplete.
- A vector access issues LANES consecutive element transactions. A scalar access issues one.

Parameters:
- LANES, 8, number of elements per vector.
- ELEM_W, 8, element and scalar width in bits; also the memory data width.
- ADDR_W, 10, data-memory word address width.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cl_mem_st  input  1  start request from decode (memory instruction present).
- cl_mem_op  input  2  10 load vector, 11 load scalar, 00 store vector, 01 store scalar.
- base_addr  input  ADDR_W  element-0 word address, sampled at start.
- vec_wdata  input  LANES*ELEM_W  store-vector data, sampled at start; lane i = bits [i*ELEM_W +: ELEM_W].
- esc_wdata  input  ELEM_W  store-scalar data, sampled at start.
- mem_rdy  output  1  high when idle or completing; low while an accepted op is in progress.
- vec_rdata  output  LANES*ELEM_W  load-vector result register.
- esc_rdata  output  ELEM_W  load-scalar result register.
- dmem_req  output  1  memory transaction request.
- dmem_we  output  1  1 = write, 0 = read; valid while dmem_req is high.
- dmem_addr  output  ADDR_W  transaction address.
- dmem_wdata  output  ELEM_W  write data.
- dmem_rdata  input  ELEM_W  read data, valid in the dmem_ack cycle.
- dmem_ack  input  1  transaction complete; ignored when dmem_req is low.

Behaviour:
- FSM states: IDLE, XFER, DONE.
- Reset (rst=1 at an edge, in any state, including mid-transfer):
  - state = IDLE, mem_rdy = 1, dmem_req = 0, dmem_we = 0.
  - dmem_addr = 0, dmem_wdata = 0, vec_rdata = 0, esc_rdata = 0, element index = 0.
  - No further memory transaction is issued after reset.
- All outputs are registered (Moore). mem_rdy = 1 in IDLE and DONE, 0 in XFER.
- Start acceptance: cl_mem_st=1 at an edge while in IDLE or DONE.
  - Latches op, base_addr, vec_wdata, esc_wdata.
  - Sets index = 0 and goes to XFER.
- cl_mem_st is ignored in XFER. Decode holds the next instruction during the stall, and that instruction is accepted at the DONE edge.
- In DONE with cl_mem_st=0, the next edge goes to IDLE.
- XFER:
  - dmem_req = 1.
  - dmem_addr = (latched base + index) mod 2^ADDR_W; the address wraps with no error.
  - dmem_we = ~op[1].
  - dmem_wdata = lane[index] for store vector, latched esc_wdata for store scalar.
- Address, we and wdata are held stable until dmem_ack.
- On an edge with dmem_ack=1:
  - Load vector: vec_rdata lane[index] <= dmem_rdata.
  - Load scalar: esc_rdata <= dmem_rdata.
  - If index is the last one (LANES-1 for vector ops, 0 for scalar ops): go to DONE and deassert dmem_req.
  - Otherwise: index+1, stay in XFER, and keep dmem_req high with the next address on the following cycle (back-to-back, 1 element/cycle maximum).
- dmem_ack may be high in the first XFER cycle (zero-wait memory).
- Latency with zero-wait memory:
  - Vector op accepted at edge 0: XFER cycles 1..LANES, DONE cycle LANES+1.
  - Scalar op: DONE at cycle 2.
- Each wait state adds one cycle.
- Result-register rules:
  - Loads update only the result register of their own kind; stores modify neither vec_rdata nor esc_rdata.
  - Lanes are written in order 0..LANES-1 and may be observed partially updated during XFER.
  - Results are guaranteed complete when mem_rdy=1 in DONE.
  - Results hold their value until overwritten by a later load.

Test Plan:
1. Load vector, zero-wait memory returning data = addr[7:0], base 0x010, start pulse → addresses 0x010..0x017 on consecutive cycles; mem_rdy low for 8 cycles; DONE at cycle 9; vec_rdata lanes 0..7 = 0x10..0x17.
2. Store vector, vec_wdata lanes = 0xA0..0xA7, base 0x3FE, memory inserts 2 wait cycles per element → 8 writes at 0x3FE,0x3FF,0x000..0x005 (wrap), each with address/data held 3 cycles; mem_rdy returns high after 24 XFER cycles.
3. Load scalar at 0x123 (rdata 0x5C) followed by store scalar 0x9E at 0x124, with cl_mem_st held high through the first op → second op accepted at the DONE edge; no IDLE cycle between them; esc_rdata = 0x5C; one write 0x9E @0x124.
4. Toggle cl_mem_st and cl_mem_op mid-XFER of a load vector → ignored; exactly 8 reads at the original addresses; op unchanged.
5. Assert rst on the 4th XFER cycle of a store vector → next cycle: dmem_req=0, mem_rdy=1, outputs zero; no further writes; a new load then completes normally.
6. Load vector with dmem_ack held high constantly → one element per cycle; dmem_req continuous for 8 cycles, then low in DONE; esc_rdata unchanged.

Source files
------------

// File: rtl/vec_mem_sequencer_if.sv
// Bundle between the vector memory sequencer, decode/control and the data memory port.
// The master modport is the sequencer side; slave is the decode plus memory side.
interface vec_mem_sequencer_if #(
  parameter int LANES  = 8,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 10
);
  logic                    cl_mem_st;
  logic [1:0]              cl_mem_op;
  logic [ADDR_W-1:0]       base_addr;
  logic [LANES*ELEM_W-1:0] vec_wdata;
  logic [ELEM_W-1:0]       esc_wdata;
  logic                    mem_rdy;
  logic [LANES*ELEM_W-1:0] vec_rdata;
  logic [ELEM_W-1:0]       esc_rdata;
  logic                    dmem_req;
  logic                    dmem_we;
  logic [ADDR_W-1:0]       dmem_addr;
  logic [ELEM_W-1:0]       dmem_wdata;
  logic [ELEM_W-1:0]       dmem_rdata;
  logic                    dmem_ack;

  modport master (
    input  cl_mem_st, cl_mem_op, base_addr, vec_wdata, esc_wdata, dmem_rdata, dmem_ack,
    output mem_rdy, vec_rdata, esc_rdata, dmem_req, dmem_we, dmem_addr, dmem_wdata
  );

  modport slave (
    output cl_mem_st, cl_mem_op, base_addr, vec_wdata, esc_wdata, dmem_rdata, dmem_ack,
    input  mem_rdy, vec_rdata, esc_rdata, dmem_req, dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Sequences one vector (LANES elements) or scalar load/store over an element-wide memory port.
// All outputs are registered; mem_rdy stalls the pipeline while a transfer is in flight.
module vec_mem_sequencer #(
  parameter int LANES  = 8,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  vec_mem_sequencer_if.master bus
);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                        r_state;
  logic [1:0]                    r_op;
  logic [ADDR_W-1:0]             r_base;
  logic [LANES-1:0][ELEM_W-1:0]  r_vecWdata;
  logic [ELEM_W-1:0]             r_escWdata;
  logic [IDX_W-1:0]              r_idx;
  logic                          r_memRdy;
  logic                          r_req;
  logic                          r_we;
  logic [ADDR_W-1:0]             r_addr;
  logic [ELEM_W-1:0]             r_wdata;
  logic [LANES-1:0][ELEM_W-1:0]  r_vecRdata;
  logic [ELEM_W-1:0]             r_escRdata;

  logic [LANES-1:0][ELEM_W-1:0]  w_startLanes;
  logic [ELEM_W-1:0]             w_startWdata;
  logic [IDX_W-1:0]              w_nextIdx;
  logic [ADDR_W-1:0]             w_nextAddr;
  logic [ELEM_W-1:0]             w_nextWdata;
  logic                          w_isLast;

  assign w_startLanes = bus.vec_wdata;

  // Next-element address/data are precomputed so the request can stay high back-to-back.
  always_comb begin
    w_nextIdx    = r_idx + IDX_W'(1);
    w_nextAddr   = r_base + ADDR_W'(w_nextIdx);
    w_nextWdata  = r_op[0] ? r_escWdata : r_vecWdata[w_nextIdx];
    w_startWdata = bus.cl_mem_op[0] ? bus.esc_wdata : w_startLanes[0];
    w_isLast     = r_op[0] ? (r_idx == '0) : (r_idx == IDX_W'(LANES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_base     <= '0;
      r_vecWdata <= '0;
      r_escWdata <= '0;
      r_idx      <= '0;
      r_memRdy   <= 1'b1;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_vecRdata <= '0;
      r_escRdata <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.cl_mem_st) begin
            r_op       <= bus.cl_mem_op;
            r_base     <= bus.base_addr;
            r_vecWdata <= w_startLanes;
            r_escWdata <= bus.esc_wdata;
            r_idx      <= '0;
            r_state    <= XFER;
            r_memRdy   <= 1'b0;
            r_req      <= 1'b1;
            r_we       <= ~bus.cl_mem_op[1];
            r_addr     <= bus.base_addr;
            r_wdata    <= w_startWdata;
          end else if (r_state == DONE) begin
            r_state <= IDLE;
          end
        end
        XFER: begin
          // Address, direction and data hold until the memory acknowledges.
          if (bus.dmem_ack) begin
            if (r_op[1]) begin
              if (r_op[0]) r_escRdata <= bus.dmem_rdata;
              else         r_vecRdata[r_idx] <= bus.dmem_rdata;
            end
            if (w_isLast) begin
              r_state  <= DONE;
              r_req    <= 1'b0;
              r_memRdy <= 1'b1;
            end else begin
              r_idx   <= w_nextIdx;
              r_addr  <= w_nextAddr;
              r_wdata <= w_nextWdata;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_req    <= 1'b0;
          r_memRdy <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mem_rdy    = r_memRdy;
  assign bus.dmem_req   = r_req;
  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_wdata = r_wdata;
  assign bus.vec_rdata  = r_vecRdata;
  assign bus.esc_rdata  = r_escRdata;
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Scoreboard bench for vec_mem_sequencer: a memory-level reference model predicts every
// transaction and result; a responder emulates memory with wait states; a monitor checks.
module tb_vec_mem_sequencer;
  localparam int LANES  = 8;
  localparam int ELEM_W = 8;
  localparam int ADDR_W = 10;
  localparam int MEM_SZ = 1 << ADDR_W;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [ELEM_W-1:0] wdata;
  } txn_t;

  typedef struct {
    logic [LANES*ELEM_W-1:0] vec;
    logic [ELEM_W-1:0]       esc;
    int                      busy;
  } res_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  int   cycleCnt;
  int   busyCnt;
  int   waitLeft;
  bit   serving;
  bit   constAck;

  logic [ELEM_W-1:0]            mem    [MEM_SZ];
  logic [ELEM_W-1:0]            refMem [MEM_SZ];
  logic [LANES-1:0][ELEM_W-1:0] refVec;
  logic [ELEM_W-1:0]            refEsc;
  txn_t txnQ[$];
  res_t resQ[$];
  int   waitQ[$];

  vec_mem_sequencer_if #(.LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) bus ();

  vec_mem_sequencer #(.LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic reportTimeout(input string name);
    checkCount++;
    $display("[TB] FAIL %s: got timeout expected completion", name);
  endtask

  // Reference model: an access is a list of element transfers applied to a flat memory.
  task automatic modelIssue(input logic [1:0] op, input logic [ADDR_W-1:0] base,
                            input logic [LANES-1:0][ELEM_W-1:0] vdata,
                            input logic [ELEM_W-1:0] sdata, input int waitSel);
    int   n;
    int   w;
    int   busy;
    txn_t t;
    res_t r;
    n    = op[0] ? 1 : LANES;
    busy = 0;
    for (int i = 0; i < n; i++) begin
      t.addr  = base + ADDR_W'(i);
      t.we    = (op[1] == 1'b0);
      t.wdata = (op == 2'b00) ? vdata[i] : sdata;
      txnQ.push_back(t);
      w = (waitSel < 0) ? int'($urandom_range(0, 3)) : waitSel;
      waitQ.push_back(w);
      busy += w + 1;
      if (t.we)        refMem[t.addr] = t.wdata;
      else if (op[0])  refEsc = refMem[t.addr];
      else             refVec[i] = refMem[t.addr];
    end
    r.vec  = refVec;
    r.esc  = refEsc;
    r.busy = busy;
    resQ.push_back(r);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [ADDR_W-1:0] base,
                               input logic [LANES*ELEM_W-1:0] vdata, input logic [ELEM_W-1:0] sdata,
                               input int waitSel, input bit keepStart, output int acceptCycle);
    int guard;
    guard = 0;
    acceptCycle = -1;
    @(negedge clk);
    while (bus.mem_rdy !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      reportTimeout("startWait");
      return;
    end
    bus.cl_mem_op = op;
    bus.base_addr = base;
    bus.vec_wdata = vdata;
    bus.esc_wdata = sdata;
    bus.cl_mem_st = 1'b1;
    modelIssue(op, base, vdata, sdata, waitSel);
    @(posedge clk);
    #1;
    acceptCycle = cycleCnt;
    if (!keepStart) bus.cl_mem_st = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(bus.mem_rdy === 1'b1 && busyCnt == 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) reportTimeout("idleWait");
    repeat (2) @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_memRdy"}, 64'(bus.mem_rdy), 64'd1);
    checkOutput({tag, "_req"},    64'(bus.dmem_req), 64'd0);
    checkOutput({tag, "_we"},     64'(bus.dmem_we), 64'd0);
    checkOutput({tag, "_addr"},   64'(bus.dmem_addr), 64'd0);
    checkOutput({tag, "_wdata"},  64'(bus.dmem_wdata), 64'd0);
    checkOutput({tag, "_vec"},    64'(bus.vec_rdata), 64'd0);
    checkOutput({tag, "_esc"},    64'(bus.esc_rdata), 64'd0);
  endtask

  // Memory responder: per element, pops a wait count, then acks with read data or commits the write.
  always @(negedge clk) begin
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = ELEM_W'($urandom);
    if (bus.dmem_req === 1'b1) begin
      if (!serving) begin
        serving  = 1'b1;
        waitLeft = 0;
        if (waitQ.size() > 0) waitLeft = waitQ.pop_front();
      end
      if (waitLeft == 0) begin
        bus.dmem_ack = 1'b1;
        serving      = 1'b0;
        if (bus.dmem_we) mem[bus.dmem_addr] = bus.dmem_wdata;
        else             bus.dmem_rdata = mem[bus.dmem_addr];
      end else begin
        waitLeft--;
      end
    end else begin
      serving = 1'b0;
      if (constAck) bus.dmem_ack = 1'b1;
    end
  end

  // Monitor: checks every requesting cycle against the head transaction and each completion.
  always @(negedge clk) begin
    txn_t t;
    res_t r;
    #2;
    if (bus.dmem_req === 1'b1) begin
      if (txnQ.size() == 0) begin
        checkOutput("unexpectedTxn", {54'd0, bus.dmem_addr}, 64'hFFFF_FFFF);
      end else begin
        t = txnQ[0];
        checkOutput("txnAddr", 64'(bus.dmem_addr), 64'(t.addr));
        checkOutput("txnWe", 64'(bus.dmem_we), 64'(t.we));
        if (t.we) checkOutput("txnWdata", 64'(bus.dmem_wdata), 64'(t.wdata));
        if (bus.dmem_ack === 1'b1) void'(txnQ.pop_front());
      end
    end
    if (rst === 1'b1) begin
      busyCnt = 0;
    end else if (bus.mem_rdy === 1'b0) begin
      busyCnt++;
    end else if (busyCnt > 0) begin
      if (resQ.size() == 0) begin
        checkOutput("unexpectedDone", 64'(busyCnt), 64'd0);
      end else begin
        r = resQ.pop_front();
        checkOutput("busyCycles", 64'(busyCnt), 64'(r.busy));
        checkOutput("vecRdata", 64'(bus.vec_rdata), 64'(r.vec));
        checkOutput("escRdata", 64'(bus.esc_rdata), 64'(r.esc));
      end
      busyCnt = 0;
    end
  end

  initial begin
    int acc1;
    int acc2;
    logic [ADDR_W-1:0] rbase;
    logic [ELEM_W-1:0] saved[LANES];
    logic [1:0] rop;
    bit keep;

    checkCount = 0;
    passCount  = 0;
    cycleCnt   = 0;
    busyCnt    = 0;
    waitLeft   = 0;
    serving    = 1'b0;
    constAck   = 1'b0;
    refVec     = '0;
    refEsc     = '0;
    for (int i = 0; i < MEM_SZ; i++) begin
      mem[i]    = ELEM_W'(i);
      refMem[i] = ELEM_W'(i);
    end
    rst            = 1'b1;
    bus.cl_mem_st  = 1'b0;
    bus.cl_mem_op  = 2'b00;
    bus.base_addr  = '0;
    bus.vec_wdata  = '0;
    bus.esc_wdata  = '0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkResetOutputs("reset");

    // Zero-wait vector load, data = low address byte.
    applyStimulus(2'b10, 10'h010, '0, '0, 0, 1'b0, acc1);
    waitIdle();

    // Vector store wrapping past the top of memory, two wait states per element.
    applyStimulus(2'b00, 10'h3FE, 64'hA7A6_A5A4_A3A2_A1A0, '0, 2, 1'b0, acc1);
    waitIdle();

    // Scalar load then scalar store, start held so the second is taken at the DONE edge.
    mem[10'h123]    = 8'h5C;
    refMem[10'h123] = 8'h5C;
    applyStimulus(2'b11, 10'h123, '0, '0, 0, 1'b1, acc1);
    applyStimulus(2'b01, 10'h124, '0, 8'h9E, 0, 1'b0, acc2);
    checkOutput("backToBackGap", 64'(acc2 - acc1), 64'd2);
    waitIdle();

    // Start request and op flicker during a vector load must not disturb it.
    applyStimulus(2'b10, 10'h0F0, '0, '0, 0, 1'b0, acc1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.cl_mem_st = 1'($urandom);
      bus.cl_mem_op = 2'($urandom);
      bus.base_addr = ADDR_W'($urandom);
    end
    @(negedge clk);
    bus.cl_mem_st = 1'b0;
    waitIdle();

    // Reset on the fourth transfer cycle of a vector store; lanes 0..3 have reached memory.
    rbase = 10'h200;
    for (int i = 0; i < LANES; i++) saved[i] = refMem[rbase + ADDR_W'(i)];
    applyStimulus(2'b00, rbase, 64'h1122_3344_5566_7788, '0, 0, 1'b0, acc1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    txnQ.delete();
    resQ.delete();
    waitQ.delete();
    for (int i = 4; i < LANES; i++) refMem[rbase + ADDR_W'(i)] = saved[i];
    refVec = '0;
    refEsc = '0;
    @(negedge clk);
    #1;
    checkResetOutputs("midReset");
    repeat (4) @(negedge clk);
    applyStimulus(2'b10, rbase, '0, '0, -1, 1'b0, acc1);
    waitIdle();

    // Scalar load so esc_rdata is nonzero, then a vector load with ack held high throughout.
    applyStimulus(2'b11, 10'h005, '0, '0, 1, 1'b0, acc1);
    waitIdle();
    constAck = 1'b1;
    applyStimulus(2'b10, 10'h3FC, '0, '0, 0, 1'b0, acc1);
    waitIdle();
    constAck = 1'b0;

    // Randomised mix of all four operations with random wait states.
    for (int n = 0; n < 40; n++) begin
      rop   = 2'($urandom);
      rbase = ADDR_W'($urandom);
      keep  = ($urandom_range(0, 3) == 0) && (n != 39);
      applyStimulus(rop, rbase, {$urandom, $urandom}, ELEM_W'($urandom), -1, keep, acc1);
    end
    bus.cl_mem_st = 1'b0;
    waitIdle();

    checkOutput("txnQueueDrained", 64'(txnQ.size()), 64'd0);
    checkOutput("resQueueDrained", 64'(resQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: got hang expected finish");
    $fatal(1, "[TB] simulation time limit");
  end
endmodule
